// File: rtl/lsu_mem_port.sv
// Load/store unit bridging the execute stage to one port of a byte-enable word RAM
// with a 1-cycle registered read. Converts B/H/W (signed/unsigned) byte-addressed
// accesses into word accesses and returns one response per accepted request.
// Optional feature macro: MISALIGN_SPLIT_EN. When defined, word-crossing accesses are
// split over two RAM accesses. When undefined, misaligned accesses are rejected.
module lsu_mem_port #(
   parameter int unsigned ADDRESS_WIDTH = 10,
   parameter int unsigned XLEN          = 32
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_req_valid,
   output logic                     o_req_ready,
   input  logic                     i_req_we,
   input  logic [2:0]               i_req_funct3,
   input  logic [XLEN-1:0]          i_req_addr,
   input  logic [XLEN-1:0]          i_req_wdata,
   output logic                     o_rsp_valid,
   output logic [XLEN-1:0]          o_rsp_rdata,
   output logic                     o_rsp_err,
   output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
   output logic [3:0]               o_mem_be,
   output logic [XLEN-1:0]          o_mem_wdata,
   output logic                     o_mem_we,
   input  logic [XLEN-1:0]          i_mem_rdata
);

   typedef enum logic [2:0] {StIdle, StAcc1, StData1, StAcc2, StData2, StResp, StErr} state_e;

   state_e                   r_state;
   logic [ADDRESS_WIDTH-1:0] r_mem_addr;
   logic [3:0]               r_mem_be;
   logic [XLEN-1:0]          r_mem_wdata;
   logic                     r_mem_we;
   logic                     r_rsp_valid;
   logic [XLEN-1:0]          r_rsp_rdata;
   logic                     r_rsp_err;
   logic                     r_we;
   logic [2:0]               r_funct3;
   logic [1:0]               r_off;
`ifdef MISALIGN_SPLIT_EN
   logic                     r_split;
   logic [3:0]               r_be_hi;
   logic [XLEN-1:0]          r_wd_hi;
   logic [XLEN-1:0]          r_w1;
`endif

   logic [1:0]      w_off;
   logic [3:0]      w_mask;
   logic [7:0]      w_be64;
   logic [2*XLEN-1:0] w_wd64;
   logic            w_is_half;
   logic            w_is_word;
   logic            w_f3_bad;
   logic            w_misalign;
   logic            w_err;
   logic            w_unused;
`ifdef MISALIGN_SPLIT_EN
   logic            w_cross;
`endif

   assign w_off     = i_req_addr[1:0];
   assign w_is_half = (i_req_funct3[1:0] == 2'b01);
   assign w_is_word = (i_req_funct3[1:0] == 2'b10);
   // 011, 11x, and any unsigned-flavoured store are illegal
   assign w_f3_bad  = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11) ||
                      (i_req_we && i_req_funct3[2]);
   assign w_misalign = (w_is_half && w_off[0]) || (w_is_word && (w_off != 2'b00));
   assign w_be64    = {4'b0000, w_mask} << w_off;
   assign w_wd64    = {{XLEN{1'b0}}, i_req_wdata} << {w_off, 3'b000};

`ifdef MISALIGN_SPLIT_EN
   assign w_cross  = (w_is_half && (w_off == 2'b11)) || (w_is_word && (w_off != 2'b00));
   assign w_err    = w_f3_bad;
   assign w_unused = ^{i_req_addr[XLEN-1:ADDRESS_WIDTH+2]};
`else
   assign w_err    = w_f3_bad || w_misalign;
   assign w_unused = ^{i_req_addr[XLEN-1:ADDRESS_WIDTH+2], w_be64[7:4], w_wd64[2*XLEN-1:XLEN]};
`endif

   // Size mask from funct3 size field
   always_comb begin
      w_mask = 4'b1111;
      unique case (i_req_funct3[1:0])
         2'b00:   w_mask = 4'b0001;
         2'b01:   w_mask = 4'b0011;
         default: w_mask = 4'b1111;
      endcase
   end

   // Shift the two-word window down to the access offset, then sign/zero extend
   function automatic logic [XLEN-1:0] f_extract(input logic [2*XLEN-1:0] d,
                                                 input logic [1:0]        off,
                                                 input logic [2:0]        f3);
      logic [XLEN-1:0] l_sh;
      l_sh = XLEN'(d >> {off, 3'b000});
      unique case (f3[1:0])
         2'b00:   f_extract = {{(XLEN-8){~f3[2] & l_sh[7]}}, l_sh[7:0]};
         2'b01:   f_extract = {{(XLEN-16){~f3[2] & l_sh[15]}}, l_sh[15:0]};
         default: f_extract = l_sh;
      endcase
   endfunction

   // Request FSM with registered RAM-side and response outputs
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_we        <= 1'b0;
         r_funct3    <= '0;
         r_off       <= '0;
`ifdef MISALIGN_SPLIT_EN
         r_split     <= 1'b0;
         r_be_hi     <= '0;
         r_wd_hi     <= '0;
         r_w1        <= '0;
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_req_valid) begin
                  if (w_err) begin
                     r_state     <= StErr;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                  end else begin
                     r_state     <= StAcc1;
                     r_mem_addr  <= i_req_addr[ADDRESS_WIDTH+1:2];
                     r_mem_be    <= w_be64[3:0];
                     r_mem_wdata <= w_wd64[XLEN-1:0];
                     r_mem_we    <= i_req_we;
                     r_we        <= i_req_we;
                     r_funct3    <= i_req_funct3;
                     r_off       <= w_off;
`ifdef MISALIGN_SPLIT_EN
                     r_split     <= w_cross;
                     r_be_hi     <= w_be64[7:4];
                     r_wd_hi     <= w_wd64[2*XLEN-1:XLEN];
`endif
                  end
               end
            end
            StAcc1: begin
               r_mem_we <= 1'b0;
               r_mem_be <= '0;
               r_state  <= StData1;
            end
            StData1: begin
`ifdef MISALIGN_SPLIT_EN
               r_w1 <= i_mem_rdata;
               if (r_split) begin
                  // Next word wraps modulo the RAM depth
                  r_state     <= StAcc2;
                  r_mem_addr  <= r_mem_addr + ADDRESS_WIDTH'(1);
                  r_mem_be    <= r_be_hi;
                  r_mem_wdata <= r_wd_hi;
                  r_mem_we    <= r_we;
               end else begin
                  r_state     <= StResp;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= r_we ? '0 : f_extract({{XLEN{1'b0}}, i_mem_rdata}, r_off, r_funct3);
               end
`else
               r_state     <= StResp;
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= r_we ? '0 : f_extract({{XLEN{1'b0}}, i_mem_rdata}, r_off, r_funct3);
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            StAcc2: begin
               r_mem_we <= 1'b0;
               r_mem_be <= '0;
               r_state  <= StData2;
            end
            StData2: begin
               r_state     <= StResp;
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= r_we ? '0 : f_extract({i_mem_rdata, r_w1}, r_off, r_funct3);
            end
`endif
            StResp: begin
               r_rsp_valid <= 1'b0;
               r_rsp_rdata <= '0;
               r_state     <= StIdle;
            end
            StErr: begin
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_state     <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_req_ready = (r_state == StIdle) && i_rst_n;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_rsp_err   = r_rsp_err;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_be    = r_mem_be;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_we    = r_mem_we;

endmodule
